cmos_fifo_axi4s_reader: RTL

Read side of the camera capture FIFO. Pops tagged words {sof, eol, pixel} written by the CMOS input formatter and emits an AXI4-Stream video master: TUSER marks start of frame, TLAST marks end of line. Sits between the capture FIFO and the video DMA. It holds back output until the first SOF after reset or resync, and reports lock and frame count.

---
 rtl/cmos_fifo_axi4s_reader.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/cmos_fifo_axi4s_reader.sv
// cmos_fifo_axi4s_reader
// Read side of the camera capture FIFO. Pops tagged words {sof, eol, pixel}
// and presents them as an AXI4-Stream video master (TUSER = start of frame,
// TLAST = end of line). Output is held back until the first SOF word after
// reset or after a RESYNC pulse.
//
// Optional feature macro: AXIS_TLAST_GEN_EN
//   defined   -> TLAST comes from an internal pixel counter (ACTIVE_WIDTH
//                pixels per line) and the stored eol bit is ignored.
//   undefined -> TLAST is the stored eol bit and no counter exists.
module cmos_fifo_axi4s_reader #(
    parameter int PIXELS_WIDTH = 16,
    parameter int ACTIVE_WIDTH = 1024
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic [PIXELS_WIDTH+1:0] FIFO_RD_DATA,
    input  logic                    FIFO_EMPTY,
    output logic                    FIFO_RD_EN,
    input  logic                    RESYNC,
    output logic [PIXELS_WIDTH-1:0] M_AXIS_TDATA,
    output logic                    M_AXIS_TVALID,
    input  logic                    M_AXIS_TREADY,
    output logic                    M_AXIS_TUSER,
    output logic                    M_AXIS_TLAST,
    output logic                    LOCKED,
    output logic [15:0]             FRAME_CNT
);

    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                  state;
    logic                    locked;
    logic [1:0]              occupancy;
    logic                    inflight;
    logic [PIXELS_WIDTH-1:0] head_data;
    logic                    head_sof;
    logic                    head_eol;
    logic [PIXELS_WIDTH-1:0] tail_data;
    logic                    tail_sof;
    logic                    tail_eol;
    logic [15:0]             frame_cnt;

    logic                    pop;
    logic                    push;
    logic                    judge_as_sync;
    logic                    word_sof;
    logic                    word_eol;
    logic [PIXELS_WIDTH-1:0] word_pixel;
    logic [2:0]              credit;

    assign word_sof   = FIFO_RD_DATA[PIXELS_WIDTH+1];
    assign word_eol   = FIFO_RD_DATA[PIXELS_WIDTH];
    assign word_pixel = FIFO_RD_DATA[PIXELS_WIDTH-1:0];

    assign M_AXIS_TVALID = (occupancy != 2'd0);
    assign M_AXIS_TDATA  = head_data;
    assign M_AXIS_TUSER  = head_sof;
    assign LOCKED        = locked;
    assign FRAME_CNT     = frame_cnt;

    assign pop = M_AXIS_TVALID & M_AXIS_TREADY;

    // A RESYNC in the same cycle as a returning word means that word is judged
    // as if we were already hunting for SOF; its own sof bit can relock.
    assign judge_as_sync = (state == SYNC) || RESYNC;
    assign push          = inflight && (!judge_as_sync || word_sof);

    // Credit: buffered words plus the outstanding read, less the beat leaving
    // this cycle, must leave room so the returning word always has a slot.
    // Gated by reset so no pop is requested while the block is held in reset.
    assign credit     = {1'b0, occupancy} + {2'b00, inflight} - {2'b00, pop};
    assign FIFO_RD_EN = ARESETN && !FIFO_EMPTY && (credit < 3'd2);

    // Track whether a read was issued last cycle, i.e. a word is returning now.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            inflight <= 1'b0;
        end else begin
            inflight <= FIFO_RD_EN;
        end
    end

    // SOF hunt / run state machine; LOCKED mirrors the RUN state.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state  <= SYNC;
            locked <= 1'b0;
        end else if (inflight && judge_as_sync && word_sof) begin
            state  <= RUN;
            locked <= 1'b1;
        end else if (RESYNC) begin
            state  <= SYNC;
            locked <= 1'b0;
        end
    end

    // Two-entry skid buffer: head drives the stream, tail absorbs the word
    // that returns while the sink is stalling.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            occupancy <= 2'd0;
            head_data <= '0;
            head_sof  <= 1'b0;
            head_eol  <= 1'b0;
            tail_data <= '0;
            tail_sof  <= 1'b0;
            tail_eol  <= 1'b0;
        end else begin
            case (occupancy)
                2'd0: begin
                    if (push) begin
                        head_data <= word_pixel;
                        head_sof  <= word_sof;
                        head_eol  <= word_eol;
                        occupancy <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head_data <= word_pixel;
                        head_sof  <= word_sof;
                        head_eol  <= word_eol;
                    end else if (push) begin
                        tail_data <= word_pixel;
                        tail_sof  <= word_sof;
                        tail_eol  <= word_eol;
                        occupancy <= 2'd2;
                    end else if (pop) begin
                        occupancy <= 2'd0;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        head_data <= tail_data;
                        head_sof  <= tail_sof;
                        head_eol  <= tail_eol;
                        if (push) begin
                            tail_data <= word_pixel;
                            tail_sof  <= word_sof;
                            tail_eol  <= word_eol;
                        end else begin
                            occupancy <= 2'd1;
                        end
                    end
                end
                default: begin
                    occupancy <= 2'd0;
                end
            endcase
        end
    end

    // Count frames as SOF beats actually accepted by the sink (wraps naturally).
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            frame_cnt <= 16'd0;
        end else if (pop && head_sof) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

`ifdef AXIS_TLAST_GEN_EN
    localparam int CNT_W = (ACTIVE_WIDTH > 1) ? $clog2(ACTIVE_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ACTIVE_WIDTH - 1);

    logic [CNT_W-1:0] pix_cnt;
    logic [CNT_W-1:0] beat_idx;

    // A SOF head is always pixel 0 regardless of where the count had got to.
    assign beat_idx     = head_sof ? '0 : pix_cnt;
    assign M_AXIS_TLAST = M_AXIS_TVALID && (beat_idx == LAST_IDX);

    // Pixel position of the next beat within the current line.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            pix_cnt <= '0;
        end else if (RESYNC) begin
            pix_cnt <= '0;
        end else if (pop) begin
            if (beat_idx == LAST_IDX) begin
                pix_cnt <= '0;
            end else begin
                pix_cnt <= beat_idx + 1'b1;
            end
        end
    end
`else
    assign M_AXIS_TLAST = head_eol;
`endif

endmodule
